// File: rtl/tage_pkg.sv
// Shared definitions for the TAGE tagged-table arbiter: entry field layout and arbiter state encoding.
package tage_pkg;
  localparam int U_W     = 2;
  localparam int CTR_W   = 3;
  localparam int TAG_W   = 11;
  localparam int U_OFS   = 0;
  localparam int CTR_OFS = U_OFS + U_W;
  localparam int TAG_OFS = CTR_OFS + CTR_W;
  localparam int ENTRY_W = TAG_W + CTR_W + U_W;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_AGING = 1'b1
  } arb_state_e;
endpackage

// File: rtl/tage_starve_counter.sv
// Saturating count of consecutive blocked cycles; starved asserts once the count reaches MAX.
module tage_starve_counter #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starved
);
  localparam int CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!reset || clr)
      cnt <= '0;
    else if (inc && (cnt != CNT_W'(MAX)))
      cnt <= cnt + 1'b1;
  end

  assign starved = (cnt == CNT_W'(MAX));
endmodule

// File: rtl/tage_table_arbiter.sv
// Single-port TAGE table bank arbiter: lookup read, update write and optional u-bit aging sweep.
// The aging sweep is compiled in only when TAGE_UBIT_AGING_EN is defined.
module tage_table_arbiter
  import tage_pkg::*;
#(
  parameter int IDX_W      = 10,
  parameter int DATA_W     = 16,
  parameter int U_W        = tage_pkg::U_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              upd_req_valid,
  output logic              upd_req_ready,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [DATA_W-1:0] upd_wdata,
  input  logic              age_start,
  output logic              age_busy,
  output logic              age_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [DATA_W-1:0] U_MASK = {{(DATA_W-U_W){1'b0}}, {U_W{1'b1}}};

  logic             grant_rd, grant_upd, grant_age;
  logic             upd_starved, age_starved, age_req;
  logic [IDX_W-1:0] age_ptr;
  logic             rd_resp_q;

  // Starved requesters jump the queue; update beats aging when both are starved.
  always_comb begin
    grant_rd  = 1'b0;
    grant_upd = 1'b0;
    grant_age = 1'b0;
    if (reset) begin
      if (upd_req_valid && upd_starved)  grant_upd = 1'b1;
      else if (age_req && age_starved)   grant_age = 1'b1;
      else if (rd_req_valid)             grant_rd  = 1'b1;
      else if (age_req)                  grant_age = 1'b1;
      else if (upd_req_valid)            grant_upd = 1'b1;
    end
  end

  assign rd_req_ready  = grant_rd;
  assign upd_req_ready = grant_upd;

  always_comb begin
    mem_en    = grant_rd | grant_upd | grant_age;
    mem_we    = grant_upd | grant_age;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (grant_rd) begin
      mem_addr = rd_idx;
    end else if (grant_upd) begin
      mem_addr  = upd_idx;
      mem_wdata = upd_wdata;
      mem_wmask = '1;
    end else if (grant_age) begin
      mem_addr  = age_ptr;
      mem_wmask = U_MASK;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) rd_resp_q <= 1'b0;
    else        rd_resp_q <= grant_rd;
  end

  // Gated so a response registered just before reset never escapes during reset.
  assign rd_resp_valid = reset && rd_resp_q;
  assign rd_resp_data  = mem_rdata;

  tage_starve_counter #(.MAX(STARVE_MAX)) u_upd_starve (
    .CLK     (CLK),
    .reset   (reset),
    .inc     (upd_req_valid && !grant_upd),
    .clr     (grant_upd),
    .starved (upd_starved)
  );

`ifdef TAGE_UBIT_AGING_EN
  arb_state_e state, state_nxt;
  logic       age_done_q;
  logic       age_last;

  assign age_last = grant_age && (age_ptr == {IDX_W{1'b1}});

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      age_ptr    <= '0;
      age_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      age_done_q <= age_last;
      if (grant_age) age_ptr <= age_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (age_start) state_nxt = ARB_AGING;
      ARB_AGING: if (age_last)  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  assign age_req  = (state == ARB_AGING);
  assign age_busy = reset && age_req;
  assign age_done = reset && age_done_q;

  tage_starve_counter #(.MAX(STARVE_MAX)) u_age_starve (
    .CLK     (CLK),
    .reset   (reset),
    .inc     (age_req && !grant_age),
    .clr     (grant_age),
    .starved (age_starved)
  );
`else
  logic unused_age_start;

  assign unused_age_start = age_start;
  assign age_req          = 1'b0;
  assign age_starved      = 1'b0;
  assign age_ptr          = '0;
  assign age_busy         = 1'b0;
  assign age_done         = 1'b0;
`endif
endmodule

// File: tb/tb_tage_table_arbiter.sv
// Bench for tage_table_arbiter: vector table for grant decisions plus read-response scoreboard.
module tb_tage_table_arbiter;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << IDX_W;

  logic              CLK = 1'b0;
  logic              reset;
  logic              rd_req_valid, rd_req_ready;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              upd_req_valid, upd_req_ready;
  logic [IDX_W-1:0]  upd_idx;
  logic [DATA_W-1:0] upd_wdata;
  logic              age_start, age_busy, age_done;
  logic              mem_en, mem_we;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_wmask, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sram    [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q   [$];
  logic              prev_acc = 1'b0;

  typedef struct {
    logic              rd_v;
    logic [IDX_W-1:0]  rd_i;
    logic              upd_v;
    logic [IDX_W-1:0]  upd_i;
    logic [DATA_W-1:0] wdata;
    logic              e_rd_rdy;
    logic              e_upd_rdy;
    logic              e_en;
    logic              e_we;
    logic [IDX_W-1:0]  e_addr;
  } vec_t;

  vec_t vecs [7];

  always #5 CLK = ~CLK;

  tage_table_arbiter #(
    .IDX_W(IDX_W), .DATA_W(DATA_W), .U_W(2), .STARVE_MAX(4)
  ) dut (
    .CLK(CLK), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_idx(rd_idx),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .upd_req_valid(upd_req_valid), .upd_req_ready(upd_req_ready),
    .upd_idx(upd_idx), .upd_wdata(upd_wdata),
    .age_start(age_start), .age_busy(age_busy), .age_done(age_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port SRAM with bit write mask and one-cycle read latency
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else        mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push expected data on read accept, compare one cycle later
  always @(negedge CLK) begin
    logic [DATA_W-1:0] e;
    if (prev_acc) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (!rd_resp_valid || rd_resp_data !== e) begin
        errors++;
        $display("FAIL rd_resp: valid %b data %h expected valid 1 data %h at %0t",
                 rd_resp_valid, rd_resp_data, e, $time);
      end
    end else begin
      checks++;
      if (rd_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_resp_spurious: valid %b expected 0 at %0t", rd_resp_valid, $time);
      end
    end
    prev_acc = rd_req_valid && rd_req_ready;
    if (prev_acc) exp_q.push_back(ref_mem[rd_idx]);
    if (upd_req_valid && upd_req_ready) ref_mem[upd_idx] = upd_wdata;
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
    vecs[1] = '{1'b0, 4'd0, 1'b1, 4'd3, 16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3};
    vecs[2] = '{1'b1, 4'd7, 1'b1, 4'd2, 16'h1357, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7};
    vecs[3] = '{1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[4] = '{1'b0, 4'd0, 1'b1, 4'd2, 16'h1357, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2};
    vecs[5] = '{1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
    vecs[6] = '{1'b1, 4'd2, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};

    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = 16'h0F00 | 16'(i << 4) | 16'h0003;
      ref_mem[i] = sram[i];
    end
    sram[5] = 16'h1234; ref_mem[5] = 16'h1234;
    sram[9] = 16'hAAAA; ref_mem[9] = 16'hAAAA;

    // Reset held with every requester active
    reset = 1'b0; age_start = 1'b1;
    rd_req_valid = 1'b1; rd_idx = 4'd1;
    upd_req_valid = 1'b1; upd_idx = 4'd6; upd_wdata = 16'hBEEF;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_rd_ready", rd_req_ready, 0);
      chk("rst_upd_ready", upd_req_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_age_busy", age_busy, 0);
      chk("rst_age_done", age_done, 0);
    end
    next_cycle();
    reset = 1'b1; age_start = 1'b0;

    // Update starved behind continuous reads: blocked 4 cycles, wins the 5th
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("starve_rd_ready", rd_req_ready, (k == 4) ? 0 : 1);
      chk("starve_upd_ready", upd_req_ready, (k == 4) ? 1 : 0);
      chk("starve_mem_addr", mem_addr, (k == 4) ? 6 : 1);
      chk("starve_mem_we", mem_we, (k == 4) ? 1 : 0);
      next_cycle();
      if (k == 4) upd_req_valid = 1'b0;
    end

    // Single read of idx 5
    rd_idx = 4'd5;
    @(negedge CLK);
    chk("rd5_ready", rd_req_ready, 1);
    chk("rd5_addr", mem_addr, 5);
    next_cycle();
    rd_req_valid = 1'b0;
    @(negedge CLK);
    chk("rd5_resp_valid", rd_resp_valid, 1);
    chk("rd5_resp_data", rd_resp_data, 16'h1234);
    next_cycle();

    // Grant decision vectors
    for (int v = 0; v < 7; v++) begin
      rd_req_valid = vecs[v].rd_v; rd_idx = vecs[v].rd_i;
      upd_req_valid = vecs[v].upd_v; upd_idx = vecs[v].upd_i; upd_wdata = vecs[v].wdata;
      @(negedge CLK);
      chk($sformatf("vec%0d_rd_ready", v), rd_req_ready, vecs[v].e_rd_rdy);
      chk($sformatf("vec%0d_upd_ready", v), upd_req_ready, vecs[v].e_upd_rdy);
      chk($sformatf("vec%0d_mem_en", v), mem_en, vecs[v].e_en);
      chk($sformatf("vec%0d_mem_we", v), mem_we, vecs[v].e_we);
      chk($sformatf("vec%0d_mem_addr", v), mem_addr, vecs[v].e_addr);
      if (vecs[v].e_we) begin
        chk($sformatf("vec%0d_mem_wdata", v), mem_wdata, vecs[v].wdata);
        chk($sformatf("vec%0d_mem_wmask", v), mem_wmask, 16'hFFFF);
      end
      next_cycle();
    end
    rd_req_valid = 1'b0; upd_req_valid = 1'b0;

    // Same-cycle read and update of idx 9: read sees old data, update follows
    rd_req_valid = 1'b1; rd_idx = 4'd9;
    upd_req_valid = 1'b1; upd_idx = 4'd9; upd_wdata = 16'h5555;
    @(negedge CLK);
    chk("same_rd_ready", rd_req_ready, 1);
    chk("same_upd_blocked", upd_req_ready, 0);
    next_cycle();
    rd_req_valid = 1'b0;
    @(negedge CLK);
    chk("same_rd_old", rd_resp_data, 16'hAAAA);
    chk("same_upd_ready", upd_req_ready, 1);
    next_cycle();
    upd_req_valid = 1'b0;
    rd_req_valid = 1'b1; rd_idx = 4'd9;
    next_cycle();
    rd_req_valid = 1'b0;
    @(negedge CLK);
    chk("same_rd_new", rd_resp_data, 16'h5555);
    next_cycle();

`ifdef TAGE_UBIT_AGING_EN
    // Full aging sweep with no other traffic
    age_start = 1'b1;
    next_cycle();
    age_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge CLK);
      chk("age_busy", age_busy, 1);
      chk("age_done_early", age_done, 0);
      chk("age_we", mem_we, 1);
      chk("age_addr", mem_addr, k);
      chk("age_wmask", mem_wmask, 16'h0003);
      chk("age_wdata", mem_wdata, 0);
      next_cycle();
      age_start = (k == 2);
    end
    age_start = 1'b0;
    @(negedge CLK);
    chk("age_end_busy", age_busy, 0);
    chk("age_end_done", age_done, 1);
    chk("age_end_mem_en", mem_en, 0);
    next_cycle();
    @(negedge CLK);
    chk("age_done_pulse", age_done, 0);
    chk("age_idle_busy", age_busy, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i][1:0] = 2'b00;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      rd_req_valid = 1'b1; rd_idx = (i == 0) ? 4'd9 : (i == 1) ? 4'd0 : 4'd15;
      next_cycle();
    end
    rd_req_valid = 1'b0;
    next_cycle();

    // Reset at sweep pointer 4 aborts the sweep silently
    age_start = 1'b1;
    next_cycle();
    age_start = 1'b0;
    begin
      int n = 0;
      @(negedge CLK);
      while (!(mem_we && mem_addr == 4) && n < 20) begin
        @(negedge CLK);
        n++;
      end
      chk("abort_reach_ptr4", n < 20, 1);
    end
    reset = 1'b0;
    @(negedge CLK);
    chk("abort_busy", age_busy, 0);
    chk("abort_mem_en", mem_en, 0);
    next_cycle();
    reset = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("abort_no_done", age_done, 0);
      chk("abort_idle", age_busy, 0);
    end
    next_cycle();
    age_start = 1'b1;
    next_cycle();
    age_start = 1'b0;
    @(negedge CLK);
    chk("restart_addr", mem_addr, 0);
    chk("restart_we", mem_we, 1);
    begin
      int n = 0;
      while (!age_done && n < 40) begin
        @(negedge CLK);
        n++;
      end
      chk("restart_done", age_done, 1);
    end
    next_cycle();
`else
    // Aging not compiled in: start pulse has no effect
    age_start = 1'b1;
    next_cycle();
    age_start = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("noage_busy", age_busy, 0);
      chk("noage_done", age_done, 0);
      chk("noage_mem_en", mem_en, 0);
      next_cycle();
    end
`endif

    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
